// File: rtl/spi_slave_mem.sv
`default_nettype none
// ============================================================================
// Module      : spi_slave_mem
// Description : SPI mode-0 responder with a local 1024x32 byte-addressed
//               memory. Decodes 16-bit read/write headers from MOSI, commits
//               1/2/4-byte little-endian writes, and serialises read data on
//               MISO. SCLK/CS_N/MOSI are oversampled in the clk domain.
// Ports       : clk, rst        - system clock, synchronous active-high reset
//               sclk_i, cs_n_i  - SPI clock and active-low select (async)
//               mosi_i, miso_o  - serial data in/out, MSB first
//               miso_oe_o       - MISO drive enable for the shared bus
//               wr_pulse_o      - one-cycle pulse when a write commits
//               frame_err_o     - one-cycle pulse on abort / reserved size
// Revision    : 1.0 - initial release
// ============================================================================
module spi_slave_mem #(
  parameter int DWIDTH     = 32,
  parameter int MEM_WIDTH  = 32,
  parameter int MEM_HEIGHT = 1024,
  parameter int AWIDTH     = $clog2(MEM_WIDTH*MEM_HEIGHT/8)
) (
  input  logic clk,
  input  logic rst,
  input  logic sclk_i,
  input  logic cs_n_i,
  input  logic mosi_i,
  output logic miso_o,
  output logic miso_oe_o,
  output logic wr_pulse_o,
  output logic frame_err_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HEADER = 3'd1,
    S_WDATA  = 3'd2,
    S_RDATA  = 3'd3,
    S_HOLD   = 3'd4
  } state_t;

  // Memory array; intentionally not reset
  logic [MEM_WIDTH-1:0] mem [0:MEM_HEIGHT-1];

  // Synchronisers: [0],[1] are the 2-flop chain, [2] is the edge register
  logic [2:0]        sclk_q;
  logic [2:0]        cs_q;
  logic [1:0]        mosi_q;

  state_t            state_q;
  logic [5:0]        bitcnt_q;
  logic [14:0]       hdr_q;
  logic [1:0]        size_q;
  logic [AWIDTH-1:0] addr_q;
  logic [DWIDTH-1:0] wsh_q;
  logic [DWIDTH-1:0] tx_q;
  logic              load_q;
  logic              miso_q;
  logic              wr_q;
  logic              err_q;

  logic              sclk_rise_d, sclk_fall_d, cs_rise_d, cs_fall_d;
  logic [15:0]       hdr_d;
  logic [AWIDTH-1:0] addr_d;
  logic [5:0]        last_idx_d;
  logic              last_bit_d;
  logic [DWIDTH-1:0] rd_shift_d;
  logic [DWIDTH-1:0] rd_sel_d;
  logic [DWIDTH-1:0] wdata_d;
  logic [3:0]        be_d;

  assign sclk_rise_d = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall_d = ~sclk_q[1] & sclk_q[2];
  assign cs_rise_d   = cs_q[1] & ~cs_q[2];
  assign cs_fall_d   = ~cs_q[1] & cs_q[2];

  // Header word including the bit arriving on this edge
  assign hdr_d = {hdr_q, mosi_q[1]};

  always_comb begin
    addr_d = hdr_d[AWIDTH-1:0];
    case (hdr_d[14:13])
      2'b01:   addr_d[0]   = 1'b0;
      2'b10:   addr_d[1:0] = 2'b00;
      default: ;
    endcase
  end

  always_comb begin
    case (size_q)
      2'b00:   last_idx_d = 6'd7;
      2'b01:   last_idx_d = 6'd15;
      default: last_idx_d = 6'd31;
    endcase
  end
  assign last_bit_d = (bitcnt_q == last_idx_d);

  // Read path: bring the addressed bytes to the top of the transmit word
  assign rd_shift_d = mem[addr_q[AWIDTH-1:2]] >> {addr_q[1:0], 3'b000};
  always_comb begin
    case (size_q)
      2'b00:   rd_sel_d = {rd_shift_d[7:0], 24'b0};
      2'b01:   rd_sel_d = {rd_shift_d[15:0], 16'b0};
      default: rd_sel_d = rd_shift_d;
    endcase
  end

  // Write path: replicate the payload across lanes, enable only the target bytes
  always_comb begin
    case (size_q)
      2'b00: begin
        wdata_d = {4{wsh_q[7:0]}};
        be_d    = 4'b0001 << addr_q[1:0];
      end
      2'b01: begin
        wdata_d = {2{wsh_q[15:0]}};
        be_d    = addr_q[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        wdata_d = wsh_q;
        be_d    = 4'b1111;
      end
    endcase
  end

  // Commit happens during the wr_pulse cycle; a coincident reset cancels it
  always_ff @(posedge clk) begin
    if (!rst && wr_q) begin
      for (int b = 0; b < 4; b++) begin
        if (be_d[b]) mem[addr_q[AWIDTH-1:2]][8*b +: 8] <= wdata_d[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_q   <= '0;
      cs_q     <= '0;
      mosi_q   <= '0;
      state_q  <= S_IDLE;
      bitcnt_q <= '0;
      hdr_q    <= '0;
      size_q   <= '0;
      addr_q   <= '0;
      wsh_q    <= '0;
      tx_q     <= '0;
      load_q   <= 1'b0;
      miso_q   <= 1'b0;
      wr_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      sclk_q <= {sclk_q[1:0], sclk_i};
      cs_q   <= {cs_q[1:0], cs_n_i};
      mosi_q <= {mosi_q[0], mosi_i};
      wr_q   <= 1'b0;
      err_q  <= 1'b0;
      load_q <= 1'b0;
      if (load_q) tx_q <= rd_sel_d;

      case (state_q)
        S_IDLE: begin
          if (cs_fall_d) begin
            state_q  <= S_HEADER;
            bitcnt_q <= '0;
          end
        end
        S_HEADER: begin
          if (cs_rise_d) begin
            state_q <= S_IDLE;
            err_q   <= 1'b1;
          end else if (sclk_rise_d) begin
            hdr_q    <= hdr_d[14:0];
            bitcnt_q <= bitcnt_q + 6'd1;
            if (bitcnt_q == 6'd15) begin
              bitcnt_q <= '0;
              size_q   <= hdr_d[14:13];
              addr_q   <= addr_d;
              if (hdr_d[14:13] == 2'b11) begin
                err_q   <= 1'b1;
                state_q <= S_HOLD;
              end else if (hdr_d[15]) begin
                state_q <= S_WDATA;
              end else begin
                state_q <= S_RDATA;
                load_q  <= 1'b1;
              end
            end
          end
        end
        S_WDATA: begin
          // Abort takes priority over a coincident final data bit
          if (cs_rise_d) begin
            state_q <= S_IDLE;
            err_q   <= 1'b1;
          end else if (sclk_rise_d) begin
            wsh_q    <= {wsh_q[DWIDTH-2:0], mosi_q[1]};
            bitcnt_q <= bitcnt_q + 6'd1;
            if (last_bit_d) begin
              wr_q    <= 1'b1;
              state_q <= S_HOLD;
            end
          end
        end
        S_RDATA: begin
          if (cs_rise_d) begin
            state_q <= S_IDLE;
            err_q   <= 1'b1;
            miso_q  <= 1'b0;
          end else begin
            if (sclk_fall_d) begin
              miso_q <= tx_q[DWIDTH-1];
              tx_q   <= {tx_q[DWIDTH-2:0], 1'b0};
            end
            // The master has already sampled the last bit at the pin edge
            if (sclk_rise_d) begin
              bitcnt_q <= bitcnt_q + 6'd1;
              if (last_bit_d) begin
                state_q <= S_HOLD;
                miso_q  <= 1'b0;
              end
            end
          end
        end
        S_HOLD: begin
          if (cs_rise_d) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign miso_o      = miso_q;
  assign miso_oe_o   = ~cs_q[1] & (state_q != S_IDLE);
  assign wr_pulse_o  = wr_q;
  assign frame_err_o = err_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_mem.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_slave_mem
// Description : Directed bench for spi_slave_mem. A byte-array memory model
//               predicts read data, write/error pulse counts per frame and the
//               idle levels of miso/miso_oe, checked every clk cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_slave_mem;

  localparam int HALF = 8;  // SCLK half period in clk cycles

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sclk_i = 1'b0;
  logic cs_n_i = 1'b1;
  logic mosi_i = 1'b0;
  logic miso_o, miso_oe_o, wr_pulse_o, frame_err_o;

  int   checks = 0;
  int   errors = 0;
  int   wr_seen = 0;
  int   err_seen = 0;
  int   cs_age = 0;
  logic cs_prev = 1'b1;
  logic rst_s = 1'b0;
  bit   live = 1'b0;       // a cleanly started frame is in progress
  bit   rd_window = 1'b0;  // miso may carry read data
  logic [7:0] mref [0:4095];
  logic [31:0] r;

  always #5 clk = ~clk;

  spi_slave_mem dut (
    .clk        (clk),
    .rst        (rst),
    .sclk_i     (sclk_i),
    .cs_n_i     (cs_n_i),
    .mosi_i     (mosi_i),
    .miso_o     (miso_o),
    .miso_oe_o  (miso_oe_o),
    .wr_pulse_o (wr_pulse_o),
    .frame_err_o(frame_err_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare process
  always @(posedge clk) begin
    rst_s = rst;
    #1;
    if (cs_n_i != cs_prev) cs_age = 0;
    else if (cs_age < 1000) cs_age++;
    cs_prev = cs_n_i;
    if (wr_pulse_o === 1'b1) wr_seen++;
    if (frame_err_o === 1'b1) err_seen++;
    if (rst_s) begin
      chk("rst_miso", {31'b0, miso_o}, 32'd0);
      chk("rst_miso_oe", {31'b0, miso_oe_o}, 32'd0);
      chk("rst_wr_pulse", {31'b0, wr_pulse_o}, 32'd0);
      chk("rst_frame_err", {31'b0, frame_err_o}, 32'd0);
    end else begin
      if (cs_age >= 4) chk("miso_oe", {31'b0, miso_oe_o}, {31'b0, (!cs_n_i && live)});
      if (!rd_window) chk("miso_idle", {31'b0, miso_o}, 32'd0);
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One SCLK period: present bit, rise (master samples miso), fall
  task automatic sbit(input logic b, output logic s);
    mosi_i = b;
    wait_clk(HALF);
    sclk_i = 1'b1;
    s = miso_o;
    wait_clk(HALF);
    sclk_i = 1'b0;
  endtask

  task automatic spi_frame(input logic rw, input logic [1:0] size, input logic [11:0] addr,
                           input logic [31:0] data, input int ndata, output logic [31:0] rd);
    logic [15:0] hdr;
    logic [31:0] sh;
    logic [31:0] exp;
    logic        s;
    int          n, nb, a, idx;
    bit          full;
    hdr  = {rw, size, 1'b0, addr};
    n    = (size == 2'b11) ? 0 : (8 << size);
    nb   = n / 8;
    a    = (nb > 0) ? (int'(addr) & ~(nb - 1)) : int'(addr);
    full = (n != 0) && (ndata >= n);
    sh   = '0;
    wr_seen  = 0;
    err_seen = 0;
    live     = 1'b1;
    cs_n_i   = 1'b0;
    wait_clk(HALF);
    for (int i = 0; i < 16; i++) sbit(hdr[15-i], s);
    if (!rw && n != 0) rd_window = 1'b1;
    for (int i = 0; i < ndata; i++) begin
      idx = ((n != 0) ? n : 32) - 1 - i;
      sbit(data[idx], s);
      sh = {sh[30:0], s};
    end
    wait_clk(HALF);
    rd_window = 1'b0;
    cs_n_i    = 1'b1;
    wait_clk(3 * HALF);
    chk("wr_pulses", wr_seen, (rw && full) ? 32'd1 : 32'd0);
    chk("frame_errs", err_seen, full ? 32'd0 : 32'd1);
    if (rw && full) begin
      for (int k = 0; k < nb; k++) mref[a+k] = data[8*k +: 8];
    end
    if (!rw && full) begin
      exp = '0;
      for (int k = 0; k < nb; k++) exp[8*k +: 8] = mref[a+k];
      chk("model_rdata", sh, exp);
    end
    rd = sh;
  endtask

  initial begin
    logic [15:0] hdr;
    logic        s;
    wait_clk(5);
    rst = 1'b0;
    wait_clk(10);
    chk("reset_miso_oe", {31'b0, miso_oe_o}, 32'd0);
    chk("reset_miso", {31'b0, miso_o}, 32'd0);

    // Aligned word write and readback
    spi_frame(1'b1, 2'b10, 12'h010, 32'hDEADBEEF, 32, r);
    spi_frame(1'b0, 2'b10, 12'h010, 32'h0, 32, r);
    chk("lit_rd4_010", r, 32'hDEADBEEF);
    spi_frame(1'b0, 2'b00, 12'h011, 32'h0, 8, r);
    chk("lit_rd1_011", r, 32'h000000BE);

    // Single byte overwrite, then word and halfword reads
    spi_frame(1'b1, 2'b00, 12'h013, 32'h000000A5, 8, r);
    spi_frame(1'b0, 2'b10, 12'h010, 32'h0, 32, r);
    chk("lit_rd4_after_b", r, 32'hA5ADBEEF);
    spi_frame(1'b0, 2'b01, 12'h012, 32'h0, 16, r);
    chk("lit_rd2_012", r, 32'h0000A5AD);

    // Unaligned word address is forced down to 0x014
    spi_frame(1'b1, 2'b10, 12'h016, 32'h11223344, 32, r);
    spi_frame(1'b0, 2'b10, 12'h014, 32'h0, 32, r);
    chk("lit_rd4_014", r, 32'h11223344);

    // Aborted write after 10 data bits leaves memory untouched
    spi_frame(1'b1, 2'b10, 12'h020, 32'hCAFEF00D, 32, r);
    spi_frame(1'b1, 2'b10, 12'h020, 32'h55AA55AA, 10, r);
    spi_frame(1'b0, 2'b10, 12'h020, 32'h0, 32, r);
    chk("lit_rd4_020_abort", r, 32'hCAFEF00D);

    // Reserved size: error after header, miso stays low, no memory effect
    spi_frame(1'b0, 2'b11, 12'h010, 32'h0, 32, r);
    chk("lit_sz3_miso", r, 32'h0);
    spi_frame(1'b1, 2'b11, 12'h010, 32'hFFFFFFFF, 32, r);
    spi_frame(1'b0, 2'b10, 12'h010, 32'h0, 32, r);
    chk("lit_rd4_010_sz3", r, 32'hA5ADBEEF);

    // Reset mid-header: rest of that frame is ignored
    hdr      = {1'b1, 2'b10, 1'b0, 12'h030};
    wr_seen  = 0;
    err_seen = 0;
    live     = 1'b1;
    cs_n_i   = 1'b0;
    wait_clk(HALF);
    for (int i = 0; i < 6; i++) sbit(hdr[15-i], s);
    rst  = 1'b1;
    live = 1'b0;
    wait_clk(1);
    rst = 1'b0;
    for (int i = 6; i < 16; i++) sbit(hdr[15-i], s);
    for (int i = 0; i < 32; i++) sbit(i[0], s);
    wait_clk(HALF);
    cs_n_i = 1'b1;
    wait_clk(3 * HALF);
    chk("rst_frame_wr", wr_seen, 32'd0);
    chk("rst_frame_err", err_seen, 32'd0);

    // Fresh frames after cs_n toggled
    spi_frame(1'b1, 2'b01, 12'h031, 32'h0000BEEF, 16, r);
    spi_frame(1'b0, 2'b01, 12'h030, 32'h0, 16, r);
    chk("lit_rd2_030", r, 32'h0000BEEF);
    spi_frame(1'b0, 2'b00, 12'h031, 32'h0, 8, r);
    chk("lit_rd1_031", r, 32'h000000BE);
    spi_frame(1'b0, 2'b10, 12'h014, 32'h0, 32, r);
    chk("lit_rd4_014_again", r, 32'h11223344);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spi_slave_mem.md
# spi_slave_mem

SPI responder with a local byte-addressed memory: one of the `NSLAVES` targets behind the SPI master. It decodes read/write instruction frames arriving on MOSI, commits writes into a 1024x32 memory, and returns read data on MISO. SCLK, CS_N and MOSI are oversampled in the single `clk` domain; the block drives the shared MISO line only while selected.

## Interface
- `DWIDTH`, 32: maximum data payload bits per frame.
- `MEM_WIDTH`, 32: memory word width.
- `MEM_HEIGHT`, 1024: memory depth in words.
- `AWIDTH`, 12: byte address width, `$clog2(MEM_WIDTH*MEM_HEIGHT/8)`.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `sclk`  in  1  SPI clock, mode 0 (CPOL=0, CPHA=0), asynchronous to `clk`.
- `cs_n`  in  1  active-low select for this slave.
- `mosi`  in  1  serial data in, MSB first.
- `miso`  out  1  serial data out, MSB first.
- `miso_oe`  out  1  MISO drive enable for the shared-bus tristate.
- `wr_pulse`  out  1  one-cycle pulse when a write commits to memory.
- `frame_err`  out  1  one-cycle pulse on an aborted or reserved-size frame.

## Operation
- Synchronizers: `sclk`, `cs_n` and `mosi` each pass through 2 flip-flops, followed by a third `sclk` register for edge detection. `sclk` frequency must be ≤ `clk`/8.
- Frame format, sampled on SCLK rising edges:
  - 16-bit header: bit15 = RW (1 = write); bits14:13 = SIZE (00 = 1 B, 01 = 2 B, 10 = 4 B, 11 = reserved); bit12 is ignored; bits11:0 = byte address.
  - The header is followed by 8, 16 or 32 data bits.
- Address alignment: the address is forced to the size boundary. 2 B clears bit0; 4 B clears bits1:0.
- Byte order: multi-byte values are little-endian in memory. The serial value is {mem[a+n-1], ..., mem[a]}, transmitted MSB first.
- States: IDLE, HEADER, WDATA, RDATA, HOLD.
  - IDLE: on synchronized `cs_n` falling, go to HEADER and clear the bit counter.
  - HEADER: shift `mosi` on each rising edge. On the 16th bit:
    - SIZE = 11: pulse `frame_err` and go to HOLD.
    - RW = 1: go to WDATA.
    - RW = 0: issue a registered memory read and go to RDATA.
  - WDATA: shift `mosi`. On the final data bit, write the masked bytes in the next cycle, pulse `wr_pulse`, and go to HOLD.
  - RDATA: the read word is latched 1 cycle after the 16th-bit edge. The MSB is driven on the next SCLK falling edge, and each subsequent falling edge shifts the next bit. After the last data bit is sampled by the master, go to HOLD.
  - HOLD: ignore SCLK until `cs_n` rises, then go to IDLE.
- `cs_n` rising in HEADER, WDATA or RDATA aborts the frame:
  - Go to IDLE and pulse `frame_err`.
  - No memory write occurs, because writes commit only on a complete frame.
- `miso_oe` = 1 whenever synchronized `cs_n` = 0 and the state is not IDLE. `miso` = 0 outside RDATA.
- Memory is a 1024x32 array with byte write enables. Its contents are not affected by `rst`.

## Timing
- Reset values: state = IDLE, `miso` = 0, `miso_oe` = 0, `wr_pulse` = 0, `frame_err` = 0, counters = 0, shift registers = 0.
- Pin-to-detect latency is 3 `clk` cycles: 2 synchronizer flops plus the edge register.
- Write commit: `wr_pulse` is high in the cycle after the final WDATA rising edge is detected. The memory is updated at the end of that cycle.
- Read turnaround: memory read data is valid 1 cycle after the 16th-bit edge. This is ≥3 cycles before the next detected falling edge, given the `sclk` ≤ `clk`/8 constraint.
- `miso` changes 1 cycle after each detected falling edge. It is stable across the next rising edge.
- `rst` mid-frame returns the block to IDLE on the next `clk` edge; no partial write occurs. A frame already in progress is ignored until `cs_n` toggles high then low.
- `cs_n` rising and a final-bit rising edge detected in the same cycle: the abort wins and there is no write.
- Extra SCLK edges after the data phase are ignored; the block stays in HOLD.

## Test plan
- Write 4 B 0xDEADBEEF to 0x010, then read 4 B from 0x010 -> MISO returns 0xDEADBEEF; one `wr_pulse`; `frame_err` stays 0.
- Write 1 B 0xA5 to 0x013 after the previous test, then read 4 B from 0x010 -> 0xA5ADBEEF. Read 2 B from 0x012 -> 0xA5AD.
- Write 4 B 0x11223344 to unaligned 0x016, then read 4 B from 0x014 -> 0x11223344.
- Write 4 B to 0x020 and raise `cs_n` after 10 data bits -> `frame_err` pulses once; no `wr_pulse`; a readback of 0x020 is unchanged.
- Header with SIZE = 11 -> `frame_err` pulses after bit 16; `miso` = 0 for the rest of the frame; memory is unchanged.
- Assert `rst` for 1 cycle mid-header -> all outputs are 0 the next cycle. A fresh frame after `cs_n` toggles completes normally, and `miso_oe` is 0 while `cs_n` is high.
